polyphase_split_stream: RTL and testbench
=========================================

Name: polyphase_split_stream

Overview:
- Streaming, sequential successor to the combinational even/odd splitter. It accepts one time-domain sample per handshake and buffers a full N-sample frame in a ping-pong (two-bank) store.
- Each frame is replayed grouped by polyphase index: all x[k*R+0], then all x[k*R+1], and so on up to x[k*R+R-1].
- Sits between the sample source and the decimation-in-time FFT stage. R=2 reproduces the even/odd split; larger R feeds radix-R stages.

Parameters:
- DATA_W, 32, sample width in bits (complex samples are packed by the caller).
- N, 16, frame length. N must be a multiple of R and at least 2.
- R, 2, number of polyphase groups, at least 2. For BIT_REVERSE_EN builds, N and R must be powers of 2.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- in_last  in  1  source marks sample N-1 of the frame; used only for the error check.
- out_data  out  DATA_W  reordered sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the sample.
- out_phase  out  max(1,$clog2(R))  polyphase index p of out_data.
- out_phase_first  out  1  first sample of the current phase group.
- out_last  out  1  final output sample of the frame.
- frame_err  out  1  sticky in_last mismatch flag.

Behaviour:
- Reset (synchronous, active-high): wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, bank_full=2'b00, frame_err=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_phase_first=0, out_phase=0, out_data=0.
  - Reset mid-frame discards all buffered data. There is no partial flush.
- Storage: mem[2][N] of DATA_W bits.
- Write side:
  - in_ready = !bank_full[wr_bank].
  - Accept when in_valid && in_ready: mem[wr_bank][wr_cnt] <= in_data and wr_cnt increments.
  - When wr_cnt==N-1: wr_cnt wraps to 0, bank_full[wr_bank] is set, wr_bank toggles.
- Error check: on every accepted sample, if in_last != (wr_cnt==N-1), frame_err is set to 1.
  - frame_err is cleared only by rst.
  - Frame counting is not resynchronised by in_last.
- Read side:
  - out_valid = bank_full[rd_bank]. Outputs are combinational from registered counters and the memory; no extra pipeline stage.
  - rd_cnt runs 0..N-1. p = rd_cnt / (N/R), k = rd_cnt % (N/R).
  - Read address is k*R+p; out_data = mem[rd_bank][addr].
  - out_phase = p. out_phase_first = out_valid && (k==0). out_last = out_valid && (rd_cnt==N-1).
  - out_data holds its value when out_valid=0 (contents of the stale location). The bench must not check it.
- Read handshake: on out_valid && out_ready, rd_cnt increments.
  - When rd_cnt==N-1: rd_cnt wraps to 0, bank_full[rd_bank] is cleared, rd_bank toggles.
- Flow control: out_data, out_phase, out_phase_first and out_last are stable while out_valid && !out_ready.
- Latency: the accept of sample N-1 at edge t makes out_valid=1 in the cycle after edge t.
- Throughput: 1 sample/cycle sustained when out_ready=1. The bank freed by the reader refills while the other bank drains.
- Simultaneous set/clear in one cycle (write completes bank A while read completes bank B): both take effect.
- No bypass: if the bank being freed this cycle is wr_bank, in_ready stays 0 this cycle and rises next cycle.
- Both banks full: in_ready=0 until the reader completes a frame.
- Both banks empty: out_valid=0.

Optional Feature:
- Macro: POLYPHASE_SPLIT_BIT_REVERSE_EN.
- When defined, read address = bit-reverse of rd_cnt over log2(N) bits. This gives the full multi-stage DIT input order instead of a single split.
  - out_phase and out_phase_first keep the same rd_cnt-based definitions as above.
- When undefined, addressing is k*R+p as above and the bit-reverse logic is absent.

Test Plan:
- N=8, R=2: push 0..7 with in_last on 7, out_ready=1 -> output 0,2,4,6,1,3,5,7; out_phase 0,0,0,0,1,1,1,1; out_phase_first on values 0 and 1; out_last on 7; frame_err=0.
- N=8, R=4: push 0..7 -> output 0,4,1,5,2,6,3,7; out_phase 0,0,1,1,2,2,3,3.
- Back-to-back frames 0..7 and 8..15 with out_ready=1 -> in_ready never drops after the first frame; the second frame outputs 8,10,12,14,9,11,13,15 with no bubbles.
- out_ready=0 while three frames are offered -> in_ready=0 after 16 accepts. Then out_ready=1 -> the first frame drains, and in_ready=1 the cycle after out_last.
- in_last asserted on sample 5 of 8 -> frame_err=1 and stays 1. Output order is unaffected. rst clears frame_err and out_valid.
- Build with POLYPHASE_SPLIT_BIT_REVERSE_EN, N=8: push 0..7 -> output 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/polyphase_split_stream.sv
// Ping-pong frame buffer that replays each N-sample frame grouped by polyphase index.
// Define POLYPHASE_SPLIT_BIT_REVERSE_EN to replay in full bit-reversed order instead.
module polyphase_split_stream #(
  parameter int DATA_W = 32,
  parameter int N      = 16,
  parameter int R      = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_W-1:0]                     in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_last,
  output logic [DATA_W-1:0]                     out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [((R > 2) ? $clog2(R) : 1)-1:0]  out_phase,
  output logic                                  out_phase_first,
  output logic                                  out_last,
  output logic                                  frame_err
);

  localparam int CW = $clog2(N);
  localparam int PW = (R > 2) ? $clog2(R) : 1;
  localparam int M  = N / R;

  logic [DATA_W-1:0] mem [2][N];
  logic              wr_bank, rd_bank;
  logic [CW-1:0]     wr_cnt, rd_cnt;
  logic [1:0]        bank_full, bank_full_nxt;
  logic              wr_fire, rd_fire, wr_end, rd_end;
  logic [CW-1:0]     grp, idx, rd_addr;

  assign in_ready  = !bank_full[wr_bank];
  assign out_valid = bank_full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_end    = (wr_cnt == CW'(N - 1));
  assign rd_end    = (rd_cnt == CW'(N - 1));

  // rd_cnt walks phase groups: grp is the phase, idx the position inside it
  always_comb begin
    grp     = rd_cnt / CW'(M);
    idx     = rd_cnt % CW'(M);
    rd_addr = '0;
`ifdef POLYPHASE_SPLIT_BIT_REVERSE_EN
    for (int i = 0; i < CW; i++) begin
      rd_addr[i] = rd_cnt[CW-1-i];
    end
`else
    rd_addr = idx * CW'(R) + grp;
`endif
  end

  assign out_data        = mem[rd_bank][rd_addr];
  assign out_phase       = PW'(grp);
  assign out_phase_first = out_valid && (idx == '0);
  assign out_last        = out_valid && rd_end;

  // a writer completing one bank and a reader freeing the other never collide
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_fire && wr_end) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_fire && rd_end) bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      bank_full <= 2'b00;
      frame_err <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_fire) begin
        mem[wr_bank][wr_cnt] <= in_data;
        if (in_last != wr_end) frame_err <= 1'b1;
        if (wr_end) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_end) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_polyphase_split_stream.sv
// Cycle-level bench for polyphase_split_stream against a frame-queue reference model.
module tb_polyphase_split_stream;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int R  = 2;
  localparam int M  = N / R;
  localparam int PW = (R > 2) ? $clog2(R) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_phase;
  logic          out_phase_first, out_last, frame_err;

  always #5 clk = ~clk;

  polyphase_split_stream #(.DATA_W(DW), .N(N), .R(R)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_phase(out_phase), .out_phase_first(out_phase_first), .out_last(out_last),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            ph;
    bit            first;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] wr_q[$];
  int            nfull;
  bit            exp_err;
  int            checks = 0;
  int            passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < $clog2(N); i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // a completed frame becomes its expected replay sequence
  task automatic finish_frame();
`ifdef POLYPHASE_SPLIT_BIT_REVERSE_EN
    for (int i = 0; i < N; i++)
      exp_q.push_back('{wr_q[bitrev(i)], i / M, (i % M) == 0, i == N - 1});
`else
    for (int p = 0; p < R; p++)
      for (int k = 0; k < M; k++)
        exp_q.push_back('{wr_q[k * R + p], p, k == 0, (p == R - 1) && (k == M - 1)});
`endif
    wr_q.delete();
    nfull++;
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit ordy);
    bit   rd_fire, wr_fire;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(nfull < 2));
    chk("out_valid", 64'(out_valid), 64'(nfull > 0));
    chk("frame_err", 64'(frame_err), 64'(exp_err));
    if (nfull > 0) begin
      chk("out_data", 64'(out_data), 64'(exp_q[0].d));
      chk("out_phase", 64'(out_phase), 64'(exp_q[0].ph));
      chk("out_phase_first", 64'(out_phase_first), 64'(exp_q[0].first));
      chk("out_last", 64'(out_last), 64'(exp_q[0].last));
    end else begin
      chk("out_phase_first_idle", 64'(out_phase_first), 64'd0);
      chk("out_last_idle", 64'(out_last), 64'd0);
    end
    rd_fire = (nfull > 0) && ordy;
    wr_fire = v && (nfull < 2);
    if (rd_fire) begin
      e = exp_q.pop_front();
      if (e.last) nfull--;
    end
    if (wr_fire) begin
      if (l != (wr_q.size() == N - 1)) exp_err = 1'b1;
      wr_q.push_back(d);
      if (wr_q.size() == N) finish_frame();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); wr_q.delete(); nfull = 0; exp_err = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_phase_first", 64'(out_phase_first), 64'd0);
    chk("rst_out_phase", 64'(out_phase), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
  endtask

  function automatic bit cur_last();
    return wr_q.size() == N - 1;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    nfull = 0; exp_err = 1'b0;
    do_reset();

    // single frame 0..N-1, sink always ready
    for (int i = 0; i < N; i++) step(1'b1, DW'(i), i == N - 1, 1'b1);
    for (int i = 0; i < 2 * N; i++) step(1'b0, '0, 1'b0, 1'b1);

    // back-to-back frames
    for (int i = 0; i < 3 * N; i++) step(1'b1, DW'(N + i), (i % N) == N - 1, 1'b1);
    for (int i = 0; i < 2 * N; i++) step(1'b0, '0, 1'b0, 1'b1);

    // sink stalled while three frames are offered, then released
    for (int i = 0; i < 3 * N; i++) step(1'b1, DW'(100 + i), cur_last(), 1'b0);
    for (int i = 0; i < 5 * N; i++) step(1'b1, DW'(200 + i), cur_last(), 1'b1);
    for (int i = 0; i < 3 * N; i++) step(1'b0, '0, 1'b0, 1'b1);

    // random valid/ready with random data
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom), cur_last(),
           $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3 * N; i++) step(1'b0, '0, 1'b0, 1'b1);

    // misplaced in_last: error is sticky, order unaffected, reset clears it
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, DW'(50 + i), i == 5, 1'b1);
    for (int i = 0; i < 2 * N; i++) step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) step(1'b1, DW'(60 + i), 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
